gate_sweep_checker: RTL and testbench
=====================================

Name: gate_sweep_checker

Overview:
Synthesizable self-check stage wrapped around the three-input gate block. It drives the block's inputs IN1..IN3 through all 8 combinations in binary order, holding each for STEP clock cycles. It samples the six gate outputs once per vector and compares them with internally computed expected values. It reports pass/fail, an error count and first-failure information. This replaces a free-running timed stimulus with a clocked sweep usable on silicon or FPGA.

Parameters:
STEP, 100, clock cycles each vector is held; legal range 2..65535.
SETTLE, 2, cycle index within a vector at which outputs are sampled; legal range 1..STEP-1.

Ports:
CLK  input  1  clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  begin sweep; sampled in IDLE and DONE only.
IN1  output  1  gate input 1, equal to vector bit 0.
IN2  output  1  gate input 2, equal to vector bit 1.
IN3  output  1  gate input 3, equal to vector bit 2.
OUT_and  input  1  gate output under test.
OUT_or  input  1  gate output under test.
OUT_nand  input  1  gate output under test.
OUT_nor  input  1  gate output under test.
OUT_not  input  1  gate output under test.
OUT_buf  input  1  gate output under test.
BUSY  output  1  high while sweeping.
DONE  output  1  high in DONE state.
PASS  output  1  DONE and ERR_CNT==0.
ERR_CNT  output  4  number of failing vectors, 0..8.
FAIL_VALID  output  1  at least one vector failed.
FAIL_VEC  output  3  index of first failing vector.
FAIL_MASK  output  6  OR-accumulated mismatch bits {buf,not,nor,nand,or,and}, bit 0 = and.

Behaviour:
- One clock domain (CLK). Reset is asynchronous and active-low (RST_N).
- Reset state, entered asynchronously at any time including mid-sweep:
  - state=IDLE, vector v=0, cycle counter cnt=0.
  - IN1..IN3=0, BUSY=0, DONE=0, PASS=0.
  - ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0, FAIL_MASK=0.
- Expected values:
  - and = IN1&IN2&IN3; or = IN1|IN2|IN3.
  - nand = ~and; nor = ~or.
  - not = ~IN1; buf = IN1.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 at an edge -> next cycle: RUN, v=0, cnt=0, BUSY=1.
  - All result registers are cleared on that same edge.
- RUN:
  - {IN3,IN2,IN1} = v, registered outputs with no combinational path from any input.
  - cnt increments each cycle from 0 to STEP-1.
  - Sample point: at the edge where cnt==SETTLE, compare the six inputs with the expected values for v.
  - If any bit mismatches:
    - ERR_CNT += 1 (one count per vector, regardless of how many bits differ).
    - FAIL_MASK |= mismatch bits.
    - If FAIL_VALID==0: FAIL_VEC=v and FAIL_VALID=1.
  - Gate outputs at any cnt other than SETTLE are ignored (glitches outside the window have no effect).
  - At cnt==STEP-1: if v<7 then v+=1 and cnt=0; if v==7 go to DONE.
  - START is ignored in RUN.
- DONE:
  - BUSY=0, DONE=1, PASS=(ERR_CNT==0).
  - IN1..IN3 hold 1,1,1.
  - Results hold until START=1 restarts exactly as from IDLE (DONE drops the following cycle).
- Timing: from the START edge to DONE=1 is 8*STEP+1 cycles. Each vector is driven for exactly STEP cycles.
- Widths: ERR_CNT cannot exceed 8, so it never overflows. cnt width is 16 bits.

Test Plan:
- Correct gate model, STEP=4, SETTLE=1, pulse START -> IN vectors 0..7 each held 4 cycles; DONE=1 at cycle 33 after START; PASS=1, ERR_CNT=0, FAIL_VALID=0.
- OUT_and stuck at 0 -> fails only at v=7: ERR_CNT=1, FAIL_VEC=7, FAIL_MASK=6'b000001, PASS=0.
- OUT_not driven as IN1 (inverted fault) -> every vector fails: ERR_CNT=8, FAIL_VEC=0, FAIL_MASK=6'b010000.
- Inject a glitch on OUT_or at cnt=3 of every vector (outside the SETTLE=1 window) -> PASS=1, ERR_CNT=0.
- Pull RST_N low while v=4, cnt=2 -> immediately IN=000, BUSY=0, all results 0; state is IDLE after release, and no activity occurs without START.
- START held high during RUN -> no restart, sweep completes in 33 cycles. Then START in DONE with the fault removed -> results are cleared and the new sweep ends with PASS=1.

Source files
------------

// File: rtl/gate_sweep_checker_if.sv
// Signal bundle between the sweep checker and the three-input gate block under test.
// Latency: none, wires only.
// Backpressure: none, the sweep is free-running once started.
interface gate_sweep_checker_if;
  logic       START;
  logic       IN1;
  logic       IN2;
  logic       IN3;
  logic       OUT_and;
  logic       OUT_or;
  logic       OUT_nand;
  logic       OUT_nor;
  logic       OUT_not;
  logic       OUT_buf;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic       FAIL_VALID;
  logic [2:0] FAIL_VEC;
  logic [5:0] FAIL_MASK;

  // Checker side: drives gate inputs and status, observes START and gate outputs.
  modport master (
    input  START, OUT_and, OUT_or, OUT_nand, OUT_nor, OUT_not, OUT_buf,
    output IN1, IN2, IN3, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC, FAIL_MASK
  );

  // Environment side: gate block plus whoever issues START and reads results.
  modport slave (
    output START, OUT_and, OUT_or, OUT_nand, OUT_nor, OUT_not, OUT_buf,
    input  IN1, IN2, IN3, BUSY, DONE, PASS, ERR_CNT, FAIL_VALID, FAIL_VEC, FAIL_MASK
  );
endinterface

// File: rtl/gate_sweep_checker.sv
// Clocked self-check: sweeps IN3..IN1 through 0..7, samples the six gate outputs once per vector.
// Latency: DONE rises 8*STEP+1 cycles after the cycle START is sampled high.
// Backpressure: none; START is only honoured in IDLE and DONE, ignored while sweeping.
module gate_sweep_checker #(
  parameter int STEP   = 100,
  parameter int SETTLE = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  gate_sweep_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [15:0] LP_LAST   = 16'(STEP - 1);
  localparam logic [15:0] LP_SETTLE = 16'(SETTLE);

  state_t      r_state;
  logic [2:0]  r_v;
  logic [15:0] r_cnt;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [3:0]  r_err_cnt;
  logic        r_fail_valid;
  logic [2:0]  r_fail_vec;
  logic [5:0]  r_fail_mask;

  logic [5:0]  w_exp;
  logic [5:0]  w_act;
  logic [5:0]  w_mis;
  logic        w_sample;
  logic        w_hit;
  logic [3:0]  w_err_nxt;

  // Gate inputs come straight from the vector register, so they are glitch-free
  // and equal v for the whole RUN window; in DONE v rests at 7, giving 1,1,1.
  assign bus.IN1 = r_v[0];
  assign bus.IN2 = r_v[1];
  assign bus.IN3 = r_v[2];

  // Expected outputs for the current vector, ordered {buf,not,nor,nand,or,and}.
  assign w_exp = {r_v[0], ~r_v[0], ~(|r_v), ~(&r_v), |r_v, &r_v};
  assign w_act = {bus.OUT_buf, bus.OUT_not, bus.OUT_nor, bus.OUT_nand, bus.OUT_or, bus.OUT_and};
  assign w_mis = w_exp ^ w_act;

  // Only the single SETTLE cycle of each vector is looked at; anything else is ignored.
  assign w_sample  = (r_state == S_RUN) && (r_cnt == LP_SETTLE);
  assign w_hit     = w_sample && (|w_mis);
  // Next error count is needed for PASS when SETTLE lands on the last cycle of vector 7.
  assign w_err_nxt = r_err_cnt + {3'd0, w_hit};

  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.PASS       = r_pass;
  assign bus.ERR_CNT    = r_err_cnt;
  assign bus.FAIL_VALID = r_fail_valid;
  assign bus.FAIL_VEC   = r_fail_vec;
  assign bus.FAIL_MASK  = r_fail_mask;

  // Sweep sequencer with result accumulation; all status outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= S_IDLE;
      r_v          <= 3'd0;
      r_cnt        <= 16'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= 4'd0;
      r_fail_valid <= 1'b0;
      r_fail_vec   <= 3'd0;
      r_fail_mask  <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // A restart from DONE behaves exactly like a start from IDLE.
          if (bus.START) begin
            r_state      <= S_RUN;
            r_v          <= 3'd0;
            r_cnt        <= 16'd0;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err_cnt    <= 4'd0;
            r_fail_valid <= 1'b0;
            r_fail_vec   <= 3'd0;
            r_fail_mask  <= 6'd0;
          end
        end

        S_RUN: begin
          if (w_hit) begin
            r_err_cnt   <= w_err_nxt;
            r_fail_mask <= r_fail_mask | w_mis;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_vec   <= r_v;
            end
          end

          if (r_cnt == LP_LAST) begin
            if (r_v == 3'd7) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_err_nxt == 4'd0);
            end else begin
              r_v   <= r_v + 3'd1;
              r_cnt <= 16'd0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: behavioural gate block with per-vector fault injection.
// Latency: checks the 8*STEP+1 cycle START-to-DONE span on every sweep.
// Backpressure: not applicable; START handling in RUN and DONE is exercised.
module tb_gate_sweep_checker;

  localparam int STEP   = 4;
  localparam int SETTLE = 1;

  logic CLK;
  logic RST_N;

  gate_sweep_checker_if bus ();

  gate_sweep_checker #(.STEP(STEP), .SETTLE(SETTLE)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Gate model: correct outputs, XOR'ed with a per-vector fault pattern and an OR glitch.
  logic [7:0][5:0] cur_flt;
  logic            glitch_q;
  logic [2:0]      w_in;
  logic [5:0]      w_good;
  logic [5:0]      w_out;

  assign w_in   = {bus.IN3, bus.IN2, bus.IN1};
  assign w_good = {w_in[0], ~w_in[0], ~(|w_in), ~(&w_in), |w_in, &w_in};
  assign w_out  = w_good ^ cur_flt[w_in] ^ {4'b0000, glitch_q, 1'b0};
  assign bus.OUT_and  = w_out[0];
  assign bus.OUT_or   = w_out[1];
  assign bus.OUT_nand = w_out[2];
  assign bus.OUT_nor  = w_out[3];
  assign bus.OUT_not  = w_out[4];
  assign bus.OUT_buf  = w_out[5];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    string           name;
    logic [7:0][5:0] flt;
    int              glitch_pos;  // cnt at which OR glitches, -1 = none
    bit              hold;        // keep START high through RUN
    int              e_err;
    int              e_vec;
    int              e_mask;
    int              e_pass;
    int              e_fvld;
  } tv_t;

  // Run one full sweep and check the per-cycle stimulus, latency and final results.
  task automatic run_sweep(input string nm, input logic [7:0][5:0] flt, input int gpos,
                           input bit hold, input int e_err, input int e_vec,
                           input int e_mask, input int e_pass, input int e_fvld);
    int n;
    int seq_bad;
    bit done_seen;
    cur_flt   = flt;
    glitch_q  = 1'b0;
    seq_bad   = 0;
    done_seen = 1'b0;
    @(negedge CLK);
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) bus.START = 1'b0;
    // Results are cleared on the START edge and nothing has been sampled yet.
    chk({nm, ":start_busy"}, int'(bus.BUSY), 1);
    chk({nm, ":start_clr"}, int'({bus.DONE, bus.FAIL_VALID, bus.ERR_CNT, bus.FAIL_MASK}), 0);
    n = 0;
    while (n < 200) begin
      if (bus.DONE) begin
        bus.START = 1'b0;
        done_seen = 1'b1;
        break;
      end
      if (n < 8 * STEP) begin
        if (int'(w_in) != n / STEP || bus.BUSY !== 1'b1) seq_bad++;
      end
      glitch_q = (gpos >= 0) && (n < 8 * STEP) && ((n % STEP) == gpos);
      @(posedge CLK);
      #1;
      n++;
    end
    glitch_q  = 1'b0;
    bus.START = 1'b0;
    if (!done_seen) $display("FAIL %s:timeout: DONE not seen within 200 cycles", nm);
    chk({nm, ":in_seq"}, seq_bad, 0);
    chk({nm, ":latency"}, n + 1, 8 * STEP + 1);
    chk({nm, ":err_cnt"}, int'(bus.ERR_CNT), e_err);
    chk({nm, ":fail_vec"}, int'(bus.FAIL_VEC), e_vec);
    chk({nm, ":fail_mask"}, int'(bus.FAIL_MASK), e_mask);
    chk({nm, ":pass"}, int'(bus.PASS), e_pass);
    chk({nm, ":fail_valid"}, int'(bus.FAIL_VALID), e_fvld);
    chk({nm, ":done_in"}, int'({bus.BUSY, w_in}), 7);
    // DONE and results hold while START stays low.
    @(posedge CLK);
    #1;
    chk({nm, ":done_hold"}, int'({bus.DONE, bus.ERR_CNT}), int'({1'b1, 4'(e_err)}));
  endtask

  tv_t tv[5];

  initial begin
    logic [7:0][5:0] rflt;
    int              rg;
    int              m_err;
    int              m_vec;
    int              m_mask;
    bit              m_fvld;

    bus.START = 1'b0;
    cur_flt   = '0;
    glitch_q  = 1'b0;
    RST_N     = 1'b0;

    // Directed vectors: {name, fault table, glitch, hold, expected results}.
    tv[0] = '{"clean", '0, -1, 1'b0, 0, 0, 0, 1, 0};
    tv[1] = '{"and_stuck0", '0, -1, 1'b0, 1, 7, 1, 0, 1};
    tv[1].flt[7] = 6'b000001;
    tv[2] = '{"not_is_in1", '0, -1, 1'b0, 8, 0, 16, 0, 1};
    for (int v = 0; v < 8; v++) tv[2].flt[v] = 6'b010000;
    tv[3] = '{"or_glitch", '0, 3, 1'b0, 0, 0, 0, 1, 0};
    tv[4] = '{"start_held", '0, -1, 1'b1, 1, 7, 1, 0, 1};
    tv[4].flt[7] = 6'b000001;

    #12;
    chk("rst_in", int'(w_in), 0);
    chk("rst_status", int'({bus.BUSY, bus.DONE, bus.PASS}), 0);
    chk("rst_results", int'({bus.ERR_CNT, bus.FAIL_VALID, bus.FAIL_VEC, bus.FAIL_MASK}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("idle_quiet", int'({bus.BUSY, bus.DONE, w_in}), 0);

    for (int i = 0; i < 5; i++)
      run_sweep(tv[i].name, tv[i].flt, tv[i].glitch_pos, tv[i].hold, tv[i].e_err,
                tv[i].e_vec, tv[i].e_mask, tv[i].e_pass, tv[i].e_fvld);

    // Restart from DONE after the held-START run, with the fault removed.
    run_sweep("restart_clean", '0, -1, 1'b0, 0, 0, 0, 1, 0);

    // Asynchronous reset in the middle of vector 4 (cnt=2) after errors have accumulated.
    cur_flt = '0;
    for (int v = 0; v < 8; v++) cur_flt[v] = 6'b010000;
    @(negedge CLK);
    bus.START = 1'b1;
    @(posedge CLK);
    #1;
    bus.START = 1'b0;
    repeat (18) @(posedge CLK);
    #1;
    chk("mid_vec", int'(w_in), 4);
    chk("mid_err", int'(bus.ERR_CNT), 5);
    #2;
    RST_N = 1'b0;
    #1;
    chk("arst_in", int'(w_in), 0);
    chk("arst_status", int'({bus.BUSY, bus.DONE, bus.PASS}), 0);
    chk("arst_results", int'({bus.ERR_CNT, bus.FAIL_VALID, bus.FAIL_VEC, bus.FAIL_MASK}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (10) @(posedge CLK);
    #1;
    chk("post_rst_idle", int'({bus.BUSY, bus.DONE, bus.ERR_CNT, w_in}), 0);

    // Random fault tables against a vector-level reference model.
    for (int it = 0; it < 20; it++) begin
      for (int v = 0; v < 8; v++)
        rflt[v] = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      case ($urandom_range(0, 3))
        0:       rg = 0;
        1:       rg = 2;
        2:       rg = 3;
        default: rg = -1;
      endcase
      m_err  = 0;
      m_vec  = 0;
      m_mask = 0;
      m_fvld = 1'b0;
      for (int v = 0; v < 8; v++) begin
        if (rflt[v] != 6'd0) begin
          m_err++;
          m_mask = m_mask | int'(rflt[v]);
          if (!m_fvld) begin
            m_fvld = 1'b1;
            m_vec  = v;
          end
        end
      end
      run_sweep($sformatf("rand%0d", it), rflt, rg, 1'b0, m_err, m_vec, m_mask,
                (m_err == 0) ? 1 : 0, int'(m_fvld));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
